// File: rtl/rv32i_types.sv
// Shared RV32I core types: the functional-unit result record carried on the CDB
// and the default number of writeback ports.
package rv32i_types;

  localparam int NUM_FU_DEFAULT     = 3;
  localparam int FIFO_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd_addr;
    logic [5:0] rob_idx;
  } inst_info_t;

  typedef struct packed {
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_t;

  typedef struct packed {
    inst_info_t  inst_info;
    logic [31:0] register_value;
    rvfi_t       rvfi;
    logic        ready_for_writeback;
  } fu_output_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Per-FU writeback result queue. Pushes into a full queue are dropped; flush
// empties the queue and overrides any same-cycle push or pop.
module wb_result_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  fu_output_t push_data,
  output logic       full,
  output logic       empty,
  output fu_output_t head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  fu_output_t       mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_data = mem[head];

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Common data bus writeback arbiter: one result queue per functional unit and
// a round-robin pick that broadcasts at most one queued result per cycle.
module cdb_writeback_arbiter
  import rv32i_types::*;
#(
  parameter  int NUM_FU     = NUM_FU_DEFAULT,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int SRC_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  fu_output_t        fu_result [NUM_FU],
  output logic [NUM_FU-1:0] fu_wb_ready,
  output logic              cdb_valid,
  output fu_output_t        cdb,
  output logic [SRC_W-1:0]  cdb_src
);

  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] pop;
  fu_output_t        head [NUM_FU];
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  grant;
  logic              grant_found;
  logic [SRC_W:0]    scan;
  logic [SRC_W-1:0]  cand;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (fu_result[i].ready_for_writeback),
      .pop       (pop[i]),
      .push_data (fu_result[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head_data (head[i])
    );

    // Ready depends only on queue state and flush, never on this cycle's grant
    assign fu_wb_ready[i] = !full[i] && !flush;
    assign pop[i]         = cdb_valid && (grant == SRC_W'(i));

    a_no_drop: assert property (@(posedge clk) disable iff (rst)
      (fu_result[i].ready_for_writeback && !flush) |-> fu_wb_ready[i])
      else $warning("writeback result from FU %0d dropped: queue full", i);
  end

  // First non-empty queue at or after rr_ptr, wrapping past NUM_FU-1
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    scan        = '0;
    cand        = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (scan >= (SRC_W+1)'(NUM_FU)) scan = scan - (SRC_W+1)'(NUM_FU);
      cand = scan[SRC_W-1:0];
      if (!grant_found && !empty[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign cdb_valid = grant_found && !flush;
  assign cdb       = cdb_valid ? head[grant] : '0;
  assign cdb_src   = cdb_valid ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (cdb_valid) begin
      rr_ptr <= (grant == SRC_W'(NUM_FU-1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: a constant vector table, directed multi-cycle
// sequences and random traffic, all checked against an arrival-order queue model.
module tb_cdb_writeback_arbiter;
  import rv32i_types::*;

  localparam int NUM_FU = 3;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  fu_output_t        fu_result [NUM_FU];
  logic [NUM_FU-1:0] fu_wb_ready;
  logic              cdb_valid;
  fu_output_t        cdb;
  logic [1:0]        cdb_src;

  always #5 clk = ~clk;

  cdb_writeback_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fu_result   (fu_result),
    .fu_wb_ready (fu_wb_ready),
    .cdb_valid   (cdb_valid),
    .cdb         (cdb),
    .cdb_src     (cdb_src)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted result in global arrival order, tagged by FU
  typedef struct {
    int         src;
    fu_output_t d;
  } ent_t;

  ent_t              mq[$];
  int                rr;
  int                m_grant;
  logic [NUM_FU-1:0] m_ready;
  logic [NUM_FU-1:0] cur_pulse;
  logic              cur_flush;
  fu_output_t        cur_res [NUM_FU];

  function automatic int m_count(input int i);
    int n = 0;
    foreach (mq[j]) if (mq[j].src == i) n++;
    return n;
  endfunction

  function automatic fu_output_t m_head(input int i);
    foreach (mq[j]) if (mq[j].src == i) return mq[j].d;
    return '0;
  endfunction

  function automatic fu_output_t mk(input int i, input logic [31:0] v);
    fu_output_t r;
    r.inst_info.opcode      = 7'h33;
    r.inst_info.rd_addr     = v[4:0];
    r.inst_info.rob_idx     = 6'(i);
    r.register_value        = v;
    r.rvfi.pc_rdata         = 32'h1000 + v * 4;
    r.rvfi.pc_wdata         = 32'h1004 + v * 4;
    r.ready_for_writeback   = 1'b1;
    return r;
  endfunction

  // Called just after a posedge: present this cycle's inputs
  task automatic drive(input logic [NUM_FU-1:0] pulse, input logic [NUM_FU-1:0][31:0] vals,
                       input logic fl);
    for (int i = 0; i < NUM_FU; i++) begin
      fu_result[i] = mk(i, pulse[i] ? vals[i] : $urandom);
      fu_result[i].ready_for_writeback = pulse[i];
      cur_res[i] = fu_result[i];
    end
    flush     = fl;
    cur_pulse = pulse;
    cur_flush = fl;
  endtask

  task automatic check_model();
    fu_output_t exp_cdb;
    m_grant = -1;
    for (int i = 0; i < NUM_FU; i++) m_ready[i] = (m_count(i) < DEPTH) && !cur_flush;
    if (!cur_flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (m_grant < 0 && m_count((rr + k) % NUM_FU) > 0) m_grant = (rr + k) % NUM_FU;
      end
    end
    exp_cdb = (m_grant >= 0) ? m_head(m_grant) : '0;
    chk("fu_wb_ready", 128'(fu_wb_ready), 128'(m_ready));
    chk("cdb_valid", 128'(cdb_valid), 128'(m_grant >= 0));
    chk("cdb_src", 128'(cdb_src), 128'((m_grant >= 0) ? m_grant : 0));
    chk("cdb", 128'(cdb), 128'(exp_cdb));
  endtask

  task automatic model_edge();
    if (cur_flush) begin
      mq.delete();
    end else begin
      if (m_grant >= 0) begin
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j].src == m_grant) begin
            mq.delete(j);
            break;
          end
        end
        rr = (m_grant + 1) % NUM_FU;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (cur_pulse[i] && m_ready[i]) mq.push_back('{src: i, d: cur_res[i]});
      end
    end
  endtask

  task automatic tick_a(input logic [NUM_FU-1:0] pulse, input logic [NUM_FU-1:0][31:0] vals,
                        input logic fl);
    drive(pulse, vals, fl);
    @(negedge clk);
    check_model();
  endtask

  task automatic tick_b();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input logic [NUM_FU-1:0] pulse, input logic [NUM_FU-1:0][31:0] vals,
                     input logic fl);
    tick_a(pulse, vals, fl);
    tick_b();
  endtask

  typedef struct {
    logic [NUM_FU-1:0]       pulse;
    logic [NUM_FU-1:0][31:0] vals;
    logic                    fl;
    logic                    exp_valid;
    logic [1:0]              exp_src;
    logic [31:0]             exp_value;
    logic [NUM_FU-1:0]       exp_ready;
  } vec_t;

  function automatic vec_t row(input logic [2:0] p, input logic [95:0] v, input logic f,
                               input logic ev, input logic [1:0] es, input logic [31:0] ex,
                               input logic [2:0] er);
    vec_t r;
    r.pulse = p; r.vals = v; r.fl = f;
    r.exp_valid = ev; r.exp_src = es; r.exp_value = ex; r.exp_ready = er;
    return r;
  endfunction

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_FU-1:0][31:0] v;
    logic [NUM_FU-1:0]       p;
    logic                    fl;

    tbl[0]  = row(3'b111, {32'h33, 32'h22, 32'h11}, 1'b0, 1'b0, 2'd0, 32'h0,   3'b111);
    tbl[1]  = row(3'b000, 96'h0,                   1'b0, 1'b1, 2'd0, 32'h11,  3'b111);
    tbl[2]  = row(3'b000, 96'h0,                   1'b0, 1'b1, 2'd1, 32'h22,  3'b111);
    tbl[3]  = row(3'b000, 96'h0,                   1'b0, 1'b1, 2'd2, 32'h33,  3'b111);
    tbl[4]  = row(3'b000, 96'h0,                   1'b0, 1'b0, 2'd0, 32'h0,   3'b111);
    tbl[5]  = row(3'b100, {32'hF00, 32'h0, 32'h0}, 1'b0, 1'b0, 2'd0, 32'h0,   3'b111);
    tbl[6]  = row(3'b000, 96'h0,                   1'b0, 1'b1, 2'd2, 32'hF00, 3'b111);
    tbl[7]  = row(3'b000, 96'h0,                   1'b0, 1'b0, 2'd0, 32'h0,   3'b111);
    tbl[8]  = row(3'b101, {32'h55, 32'h0, 32'h44}, 1'b0, 1'b0, 2'd0, 32'h0,   3'b111);
    tbl[9]  = row(3'b000, 96'h0,                   1'b0, 1'b1, 2'd0, 32'h44,  3'b111);
    tbl[10] = row(3'b000, 96'h0,                   1'b0, 1'b1, 2'd2, 32'h55,  3'b111);
    tbl[11] = row(3'b000, 96'h0,                   1'b0, 1'b0, 2'd0, 32'h0,   3'b111);
    tbl[12] = row(3'b010, {32'h0, 32'h66, 32'h0},  1'b1, 1'b0, 2'd0, 32'h0,   3'b000);
    tbl[13] = row(3'b000, 96'h0,                   1'b0, 1'b0, 2'd0, 32'h0,   3'b111);

    // Reset state
    rst = 1'b1;
    drive('0, '0, 1'b0);
    mq.delete();
    rr = 0;
    @(negedge clk);
    chk("reset cdb_valid", 128'(cdb_valid), 128'(0));
    chk("reset cdb", 128'(cdb), 128'(0));
    chk("reset cdb_src", 128'(cdb_src), 128'(0));
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Constant vector table: single result, contention, round-robin order, flush
    for (int r = 0; r < 14; r++) begin
      tick_a(tbl[r].pulse, tbl[r].vals, tbl[r].fl);
      chk($sformatf("tbl[%0d] cdb_valid", r), 128'(cdb_valid), 128'(tbl[r].exp_valid));
      chk($sformatf("tbl[%0d] fu_wb_ready", r), 128'(fu_wb_ready), 128'(tbl[r].exp_ready));
      if (tbl[r].exp_valid) begin
        chk($sformatf("tbl[%0d] cdb_src", r), 128'(cdb_src), 128'(tbl[r].exp_src));
        chk($sformatf("tbl[%0d] value", r), 128'(cdb.register_value), 128'(tbl[r].exp_value));
      end
      tick_b();
    end

    // Backpressure: FU1 fills while FU2/FU0 take the grant, 0xC is dropped
    cyc(3'b010, {32'h0, 32'h5, 32'h0}, 1'b0);
    cyc(3'b111, {32'h9, 32'hA, 32'h8}, 1'b0);
    cyc(3'b011, {32'h0, 32'hB, 32'h7}, 1'b0);
    tick_a(3'b010, {32'h0, 32'hC, 32'h0}, 1'b0);
    chk("full fu_wb_ready[1]", 128'(fu_wb_ready[1]), 128'(0));
    tick_b();
    tick_a('0, '0, 1'b0);
    chk("bp first value", 128'(cdb.register_value), 128'(32'hA));
    tick_b();
    cyc('0, '0, 1'b0);
    tick_a('0, '0, 1'b0);
    chk("bp second value", 128'(cdb.register_value), 128'(32'hB));
    tick_b();
    tick_a('0, '0, 1'b0);
    chk("bp no 0xC", 128'(cdb_valid), 128'(0));
    tick_b();

    // Flush with FU0 holding 2 entries and FU2 holding 1, FU1 pulsing
    cyc(3'b101, {32'hB1, 32'h0, 32'hA1}, 1'b0);
    cyc(3'b101, {32'hB2, 32'h0, 32'hA2}, 1'b0);
    tick_a(3'b010, {32'h0, 32'h77, 32'h0}, 1'b1);
    chk("flush cdb_valid", 128'(cdb_valid), 128'(0));
    tick_b();
    tick_a('0, '0, 1'b0);
    chk("post-flush ready", 128'(fu_wb_ready), 128'(3'b111));
    chk("post-flush cdb_valid", 128'(cdb_valid), 128'(0));
    tick_b();
    cyc(3'b010, {32'h0, 32'h88, 32'h0}, 1'b0);
    cyc('0, '0, 1'b0);

    // Asynchronous reset mid-cycle with entries queued
    cyc(3'b111, {32'h93, 32'h92, 32'h91}, 1'b0);
    tick_a('0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async rst cdb_valid", 128'(cdb_valid), 128'(0));
    chk("async rst cdb", 128'(cdb), 128'(0));
    mq.delete();
    rr = 0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc('0, '0, 1'b0);
    cyc(3'b100, {32'hAB, 32'h0, 32'h0}, 1'b0);
    tick_a('0, '0, 1'b0);
    chk("post-rst first value", 128'(cdb.register_value), 128'(32'hAB));
    tick_b();

    // Back-to-back stream from FU1 alone: pointers wrap, ready stays high
    for (int n = 0; n < 10; n++) begin
      tick_a(3'b010, {32'h0, 32'h100 + 32'(n), 32'h0}, 1'b0);
      chk("wrap fu_wb_ready[1]", 128'(fu_wb_ready[1]), 128'(1));
      tick_b();
    end
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);

    // Random traffic; pulses respect the model's readiness, flush is rare
    for (int n = 0; n < 400; n++) begin
      fl = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NUM_FU; i++) begin
        v[i] = $urandom;
        p[i] = ($urandom_range(0, 1) == 1) && (fl || m_count(i) < DEPTH);
      end
      cyc(p, v, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_writeback_arbiter.md
CDB_WRITEBACK_ARBITER -- requirements
Module: cdb_writeback_arbiter

Interface
REQ-001 Parameter NUM_FU, default 3, number of functional-unit result ports (ALU, ALU, multiplier).
REQ-002 Parameter FIFO_DEPTH, default 2, entries per per-FU result queue (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline flush (mispredict); discards all queued results.
REQ-006 fu_result[NUM_FU]  input  fu_output_t each  FU result; it is valid when its .ready_for_writeback is 1.
REQ-007 fu_wb_ready[NUM_FU]  output  1 each  queue i can accept a result this cycle.
REQ-008 cdb_valid  output  1  a result is broadcast on the CDB this cycle.
REQ-009 cdb  output  fu_output_t  broadcast result (inst_info, register_value, rvfi fields unchanged).
REQ-010 cdb_src  output  $clog2(NUM_FU)  index of the FU whose result is broadcast.

Function
REQ-011 Each FU port SHALL own a FIFO_DEPTH-entry FIFO with head pointer, tail pointer and a count of width $clog2(FIFO_DEPTH)+1.
REQ-012 fu_wb_ready[i] SHALL be 1 iff count[i] < FIFO_DEPTH and flush is 0, decoded from registers only (no path from cdb or fu_result).
REQ-013 A result SHALL be enqueued at the posedge when fu_result[i].ready_for_writeback=1 and fu_wb_ready[i]=1.
REQ-014 A result presented while fu_wb_ready[i]=0 SHALL be dropped, and SHALL fire a simulation assertion.
REQ-015 Per cycle, the arbiter SHALL grant at most one non-empty FIFO: first index at or after rr_ptr, searching upward with wrap.
REQ-016 cdb, cdb_src and cdb_valid SHALL be driven combinationally from the granted FIFO's head entry.
- cdb_valid=0 when all FIFOs are empty or flush=1.
- cdb='0 whenever cdb_valid=0.
REQ-017 The granted head SHALL be dequeued at the posedge, and rr_ptr SHALL become (grant+1) mod NUM_FU.
REQ-018 rr_ptr SHALL be unchanged in cycles with no grant.
REQ-019 Latency: a result enqueued at edge t SHALL be eligible for broadcast in the cycle after t (minimum 1 cycle FU-pulse to CDB).
REQ-020 Enqueue and dequeue on the same FIFO in the same cycle SHALL leave count unchanged and move both pointers.
- This cannot occur on a full FIFO, because of REQ-012.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 Results from one FU SHALL be broadcast in arrival order.
REQ-023 Across FUs, no non-empty FIFO SHALL wait more than NUM_FU-1 grants.
REQ-024 Flush at edge t SHALL:
- clear all counts and pointers;
- discard any same-cycle enqueue;
- perform no dequeue;
- leave rr_ptr unchanged.
REQ-025 With flush=0, fu_wb_ready SHALL be 1 again in the cycle after the flush.

Reset
REQ-026 On rst assertion, independent of clk:
- all counts, head and tail pointers, and rr_ptr SHALL go to 0;
- cdb_valid=0, cdb='0, cdb_src=0;
- fu_wb_ready all 1 once rst deasserts.
REQ-027 FIFO data storage need not be reset.
REQ-028 Reset mid-stream SHALL discard every queued result; nothing from before reset appears on the CDB.

Structure
REQ-029 The shared package rv32i_types SHALL hold fu_output_t (existing) and the NUM_FU default constant.
REQ-030 The per-FU queue SHALL be one sub-module, wb_result_fifo: parameterised depth, push, pop, flush, full, empty, head data.
- The arbiter SHALL instantiate NUM_FU copies of it.
REQ-031 The round-robin pick SHALL be combinational logic inside cdb_writeback_arbiter.

Verification (NUM_FU=3, FIFO_DEPTH=2)
REQ-032 Single result: FU2 pulses register_value=32'h0000_0F00 at cycle 5 -> cycle 6: cdb_valid=1, cdb_src=2, value 0x0F00; cycle 7: cdb_valid=0.
REQ-033 Contention: FU0, FU1 and FU2 all pulse at cycle 3 with rr_ptr=0 -> broadcasts in cycles 4, 5, 6 from src 0, 1, 2; rr_ptr=0 afterwards.
REQ-034 Full/backpressure: FU1 pulses 0xA, 0xB, 0xC in cycles 1-3 while FU0 holds the grant with a continuous stream.
- fu_wb_ready[1]=0 once 0xA and 0xB are queued.
- 0xC is presented while not ready -> assertion fires and 0xC is never broadcast.
- 0xA then 0xB broadcast in order when FU1 is granted.
REQ-035 Flush: FU0 holds 2 entries and FU2 holds 1 entry; flush=1 at cycle 10 while FU1 pulses.
- Cycle 10: cdb_valid=0.
- Cycle 11: all fu_wb_ready=1 and no stale result ever broadcast.
REQ-036 Async reset: assert rst mid-cycle with entries queued -> cdb_valid drops to 0 before the next edge; after release, the first broadcast is only a newly pulsed result.
REQ-037 Wrap: 10 back-to-back results from FU1 alone, one per cycle -> pointers wrap, fu_wb_ready[1] stays 1, values appear in order with 1-cycle latency.
